// File: rtl/module_7seg_mux_pkg.sv
// Shared types, segment lookup table and parameter sanity check for the
// multiplexed 7-segment driver.
package pkg_7seg;

   // Segment vector {g,f,e,d,c,b,a}, bit 0 = a
   typedef logic [6:0] seg_t;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   // Active-high hex glyphs; polarity is applied after lookup
   localparam seg_t HEX_TO_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
      7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
   };

   // The slot must leave at least one SHOW cycle after the dead time
   function automatic bit slot_params_ok(input int slot_div, input int blank_cycles);
      return (slot_div > blank_cycles) && (slot_div > 0);
   endfunction

endpackage

// File: rtl/module_7seg_mux_hex_to_seg.sv
// Combinational nibble -> 7-segment decode with selectable pin polarity.
module module_hex_to_seg
   import pkg_7seg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] nibble_i,
   output seg_t       seg_o
);

   assign seg_o = ACTIVE_LOW ? ~HEX_TO_SEG[nibble_i] : HEX_TO_SEG[nibble_i];

endmodule

// File: rtl/module_7seg_mux.sv
// Time-multiplexed N-digit 7-segment driver: shadow-latched hex word,
// fixed slot rate with a dead-time gap, per-digit enable, decimal points
// and leading-zero suppression. All pins are registered.
module module_7seg_mux
   import pkg_7seg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int CLK_FREQ_HZ    = 27_000_000,
   parameter int REFRESH_HZ     = 1000,
   parameter int BLANK_CYCLES   = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*N_DIGITS-1:0] data,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   digit_en,
   input  logic                  load,
   input  logic                  lz_suppress,
   output logic [6:0]            display,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   anodo
);

   localparam int SLOT_DIV    = CLK_FREQ_HZ / REFRESH_HZ;
   localparam int SHOW_CYCLES = SLOT_DIV - BLANK_CYCLES;
   localparam int CW          = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
   localparam int IW          = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam seg_t                SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic                DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_ACTIVE_LOW}};

   if (!slot_params_ok(SLOT_DIV, BLANK_CYCLES)) begin : g_bad_params
      $error("module_7seg_mux: SLOT_DIV must exceed BLANK_CYCLES");
   end

   state_t                    state_q;
   logic [CW-1:0]             cnt_q;
   logic [IW-1:0]             idx_q;
   logic [N_DIGITS-1:0][3:0]  data_q;
   logic [N_DIGITS-1:0]       dp_q;
   logic [N_DIGITS-1:0]       en_q;

   seg_t                      display_d;
   logic                      dp_d;
   logic [N_DIGITS-1:0]       anodo_d;
   logic [N_DIGITS-1:0]       upper_zero;
   logic                      zero_run;
   seg_t                      seg_dec;
   logic                      show, dig_en, lz_blank, seg_on, an_on;

   // Shadow registers: captured only on a load strobe, reset wins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
         dp_q   <= '0;
         en_q   <= '0;
      end else if (load) begin
         data_q <= data;
         dp_q   <= dp_in;
         en_q   <= digit_en;
      end
   end

   // Slot sequencer: dead time, then display window; digit advances on leaving SHOW
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BLANK;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            BLANK: begin
               if (int'(cnt_q) + 1 >= BLANK_CYCLES) begin
                  state_q <= SHOW;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            SHOW: begin
               if (int'(cnt_q) + 1 >= SHOW_CYCLES) begin
                  state_q <= BLANK;
                  cnt_q   <= '0;
                  idx_q   <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= BLANK;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // upper_zero[i] = nibbles i..N_DIGITS-1 are all zero
   always_comb begin
      upper_zero = '0;
      zero_run   = 1'b1;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_run      = zero_run & (data_q[i] == 4'h0);
         upper_zero[i] = zero_run;
      end
   end

   module_hex_to_seg #(
      .ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_dec (
      .nibble_i (data_q[idx_q]),
      .seg_o    (seg_dec)
   );

   // Pin values for the current slot; a zero-suppressed digit keeps its anode only to light its dp
   always_comb begin
      show      = (state_q == SHOW);
      dig_en    = en_q[idx_q];
      lz_blank  = lz_suppress && (idx_q != '0) && upper_zero[idx_q];
      seg_on    = show && dig_en && !lz_blank;
      an_on     = show && dig_en && (!lz_blank || dp_q[idx_q]);
      display_d = seg_on ? seg_dec : SEG_OFF;
      dp_d      = (an_on && dp_q[idx_q]) ? ~DP_OFF : DP_OFF;
      anodo_d   = an_on ? ((N_DIGITS'(1) << idx_q) ^ AN_OFF) : AN_OFF;
   end

   // Output registers keep the pins glitch-free
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         display <= SEG_OFF;
         dp      <= DP_OFF;
         anodo   <= AN_OFF;
      end else begin
         display <= display_d;
         dp      <= dp_d;
         anodo   <= anodo_d;
      end
   end

endmodule

// File: tb/tb_module_7seg_mux.sv
// Randomized + directed bench for module_7seg_mux against a slot-arithmetic model.
module tb_module_7seg_mux;

   localparam int N    = 4;
   localparam int BLK  = 2;
   localparam int SLOT = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  digit_en = '0;
   logic        load = 1'b0;
   logic        lz_suppress = 1'b0;
   logic [6:0]  display;
   logic        dp;
   logic [3:0]  anodo;

   int checks = 0;
   int errors = 0;

   module_7seg_mux #(
      .N_DIGITS       (N),
      .CLK_FREQ_HZ    (1000),
      .REFRESH_HZ     (100),
      .BLANK_CYCLES   (BLK),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data        (data),
      .dp_in       (dp_in),
      .digit_en    (digit_en),
      .load        (load),
      .lz_suppress (lz_suppress),
      .display     (display),
      .dp          (dp),
      .anodo       (anodo)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;  default: return 7'b1110001;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: pins after the k-th edge since reset release
   int          k = 0;
   logic [15:0] m_data = '0;
   logic [3:0]  m_dp = '0, m_en = '0;
   logic [6:0]  e_disp = 7'h7F;
   logic        e_dp = 1'b1;
   logic [3:0]  e_an = 4'hF;
   logic        e_blank = 1'b1;
   logic        model_ok = 1'b0;

   always @(posedge clk) begin : model
      int   q, d;
      logic lzd, shown, an_on;
      logic [3:0] one;
      if (!rst_n) begin
         k = 0; m_data = '0; m_dp = '0; m_en = '0;
         e_disp = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_blank = 1'b1;
      end else begin
         k++;
         q       = (k - 1) % SLOT;
         d       = ((k - 1) / SLOT) % N;
         shown   = (q >= BLK);
         e_blank = !shown;
         lzd     = lz_suppress && (d != 0) && ((m_data >> (4 * d)) == 16'h0);
         an_on   = shown && m_en[d] && (!lzd || m_dp[d]);
         one     = 4'b0001 << d;
         e_an    = an_on ? ~one : 4'hF;
         e_disp  = (shown && m_en[d] && !lzd) ? ~hex_seg(m_data[4*d +: 4]) : 7'h7F;
         e_dp    = !(an_on && m_dp[d]);
         if (load) begin
            m_data = data; m_dp = dp_in; m_en = digit_en;
         end
      end
      model_ok = 1'b1;
   end

   // Every-cycle comparison against the model plus pin-safety properties
   always @(negedge clk) begin
      if (model_ok) begin
         check("display", 32'(display), 32'(e_disp));
         check("dp", 32'(dp), 32'(e_dp));
         check("anodo", 32'(anodo), 32'(e_an));
         check("onehot", 32'($countones(~anodo) <= 1), 32'd1);
         if (e_blank) check("blank_anodes", 32'(anodo), 32'hF);
      end
   end

   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
      data = d; dp_in = p; digit_en = e; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_anode(input string name, input logic [3:0] t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (anodo !== t && n < 100);
      check(name, 32'(anodo), 32'(t));
   endtask

   task automatic seen_anodes(output logic [3:0] s, output logic dp_lit);
      s = '0; dp_lit = 1'b0;
      repeat (40) begin
         @(negedge clk);
         s = s | ~anodo;
         dp_lit = dp_lit | ~dp;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] s;
      logic       dpl;
      int         n;

      // Reset with a load strobe present: reset must win
      rst_n = 1'b0; load = 1'b1; data = 16'hFFFF; dp_in = 4'hF; digit_en = 4'hF;
      repeat (3) @(negedge clk);
      check("rst_display", 32'(display), 32'h7F);
      check("rst_dp", 32'(dp), 32'd1);
      check("rst_anodo", 32'(anodo), 32'hF);
      rst_n = 1'b1; load = 1'b0;
      seen_anodes(s, dpl);
      check("rst_beats_load", 32'(s), 32'h0);

      // Fresh reset, then first slot timing
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; load = 1'b1; data = 16'h0; digit_en = 4'hF; dp_in = 4'h0;
      @(negedge clk);
      load = 1'b0;
      check("rel_blank0", 32'(anodo), 32'hF);
      @(negedge clk);
      check("rel_blank1", 32'(anodo), 32'hF);
      repeat (8) begin
         @(negedge clk);
         check("rel_show_an", 32'(anodo), 32'hE);
         check("rel_show_seg", 32'(display), 32'h40);
      end
      @(negedge clk);
      check("rel_gap", 32'(anodo), 32'hF);

      // Plain hex word, scan order and period
      do_load(16'h12AF, 4'h0, 4'hF);
      wait_anode("w_d0", 4'b1110); check("seg_F", 32'(display), 32'b0001110);
      check("dp_off", 32'(dp), 32'd1);
      wait_anode("w_d1", 4'b1101); check("seg_A", 32'(display), 32'b0001000);
      wait_anode("w_d2", 4'b1011); check("seg_2", 32'(display), 32'b0100100);
      wait_anode("w_d3", 4'b0111); check("seg_1", 32'(display), 32'b1111001);
      wait_anode("w_wrap", 4'b1110);
      n = 0;
      do begin @(negedge clk); n++; end while (anodo == 4'b1110 && n < 100);
      do begin @(negedge clk); n++; end while (anodo != 4'b1110 && n < 100);
      check("period", 32'(n), 32'd40);

      // Leading-zero suppression
      lz_suppress = 1'b1;
      do_load(16'h0070, 4'h0, 4'hF);
      seen_anodes(s, dpl);
      check("lz_0070", 32'(s), 32'h3);
      wait_anode("w_lz1", 4'b1101); check("seg_7", 32'(display), 32'b1111000);
      wait_anode("w_lz0", 4'b1110); check("seg_0", 32'(display), 32'b1000000);
      do_load(16'h0000, 4'h0, 4'hF);
      seen_anodes(s, dpl);
      check("lz_0000", 32'(s), 32'h1);
      do_load(16'h0005, 4'b1000, 4'hF);
      seen_anodes(s, dpl);
      check("lz_dp_anodes", 32'(s), 32'h9);
      wait_anode("w_lzdp", 4'b0111);
      check("lz_dp_seg", 32'(display), 32'h7F);
      check("lz_dp_pin", 32'(dp), 32'd0);

      // Disabled digit with a dp request stays dark
      lz_suppress = 1'b0;
      do_load(16'h12AF, 4'b0100, 4'b1011);
      seen_anodes(s, dpl);
      check("en_anodes", 32'(s), 32'hB);
      check("en_dp_dark", 32'(dpl), 32'd0);
      wait_anode("w_en1", 4'b1101);
      check("en_d1_dp", 32'(dp), 32'd1);

      // Mid-slot reload takes effect immediately, slot timing unchanged
      do_load(16'h0003, 4'h0, 4'hF);
      wait_anode("w_mid", 4'b1110);
      check("mid_seg3", 32'(display), 32'b0110000);
      data = 16'h0008; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("mid_hold", 32'(display), 32'b0110000);
      @(negedge clk);
      check("mid_seg8", 32'(display), 32'b0000000);
      check("mid_an", 32'(anodo), 32'hE);

      // Randomized traffic with occasional resets
      repeat (2000) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 31) == 0) lz_suppress = ~lz_suppress;
         if ($urandom_range(0, 11) == 0) begin
            for (int i = 0; i < N; i++)
               data[4*i +: 4] = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
            dp_in = 4'($urandom_range(0, 15));
            digit_en = 4'($urandom_range(0, 15));
            load = 1'b1;
         end else begin
            load = 1'b0;
         end
      end
      @(negedge clk);
      rst_n = 1'b1; load = 1'b0;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
